// File: rtl/expr_pkg.sv
// rtl/expr_pkg.sv - shared constants, state encodings and character classes for the expression arbiter
package expr_pkg;

  localparam logic [7:0] ZERO = 8'h30;
  localparam logic [7:0] NINE = 8'h39;
  localparam logic [7:0] PLUS = 8'h2B;
  localparam logic [7:0] STAR = 8'h2A;
  localparam logic [7:0] EQ   = 8'h3D;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } top_state_t;

  typedef enum logic [1:0] {
    EXP_D  = 2'd0,
    AFT_D  = 2'd1,
    AFT_OP = 2'd2,
    ERR    = 2'd3
  } rec_state_t;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= ZERO) && (c <= NINE);
  endfunction

  function automatic logic is_op(input logic [7:0] c);
    return (c == PLUS) || (c == STAR);
  endfunction

endpackage

// File: rtl/expr_check_core.sv
// rtl/expr_check_core.sv - digit/operator alternation recognizer with sticky error state
module expr_check_core
  import expr_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       en,
  input  logic [7:0] ch,
  output logic [1:0] state
);

  rec_state_t st, st_nx;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) st <= EXP_D;
    else     st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    if (start) begin
      st_nx = EXP_D;
    end else if (en) begin
      case (st)
        EXP_D:   st_nx = is_digit(ch) ? AFT_D : ERR;
        AFT_D:   st_nx = is_op(ch) ? AFT_OP : ERR;
        AFT_OP:  st_nx = is_digit(ch) ? AFT_D : ERR;
        default: st_nx = ERR;
      endcase
    end
  end

  assign state = st;

endmodule

// File: rtl/expr_stream_arbiter.sv
// rtl/expr_stream_arbiter.sv - round-robin arbiter granting whole expressions to one shared recognizer
module expr_stream_arbiter
  import expr_pkg::*;
#(
  parameter int          NREQ    = 2,
  parameter int          MAXLEN  = 64,
  parameter int          TIMEOUT = 255,
  parameter logic [7:0]  TERM    = EQ
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              busy,
  output logic              res_valid,
  output logic              res_ok,
  output logic              res_tmo,
  output logic [2:0]        res_src,
  output logic [6:0]        res_len
);

  localparam logic [3:0] NREQ4    = 4'(NREQ);
  localparam logic [7:0] MAXLEN_L = 8'(MAXLEN);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  top_state_t state, state_nx;
  logic [2:0] rr_ptr;
  logic [2:0] grant;
  logic [6:0] len;
  logic [7:0] tmo_cnt;
  logic [1:0] rec_state;

  logic       found;
  logic [2:0] pick;
  logic [3:0] rr_idx;
  logic       gvalid;
  logic [7:0] gdata;
  logic       xfer;
  logic       is_term;
  logic       tmo_hit;
  logic       rec_start;
  logic       rec_en;

  // Round-robin search: first valid source at or after rr_ptr, wrapping at NREQ.
  always_comb begin
    found  = 1'b0;
    pick   = 3'd0;
    rr_idx = 4'd0;
    for (int k = 0; k < NREQ; k++) begin
      rr_idx = {1'b0, rr_ptr} + 4'(k);
      if (rr_idx >= NREQ4) rr_idx = rr_idx - NREQ4;
      for (int j = 0; j < NREQ; j++) begin
        if (!found && rr_idx == 4'(j) && req_valid[j]) begin
          found = 1'b1;
          pick  = 3'(j);
        end
      end
    end
  end

  always_comb begin
    gvalid = 1'b0;
    gdata  = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == 3'(i)) begin
        gvalid = req_valid[i];
        gdata  = req_data[8*i +: 8];
      end
    end
  end

  assign xfer      = (state == S_STREAM) && gvalid;
  assign is_term   = (gdata == TERM);
  assign tmo_hit   = (state == S_STREAM) && !gvalid && (tmo_cnt == TMO_LAST);
  assign rec_start = (state == S_IDLE) && found;
  assign rec_en    = xfer && !is_term;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    busy      = 1'b0;
    res_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (found) state_nx = S_STREAM;
      end
      S_STREAM: begin
        busy = 1'b1;
        for (int i = 0; i < NREQ; i++) req_ready[i] = (grant == 3'(i));
        if ((xfer && is_term) || tmo_hit) state_nx = S_DONE;
      end
      S_DONE: begin
        res_valid = 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Result fields are loaded on the way into DONE and then held until the next expression ends.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rr_ptr  <= 3'd0;
      grant   <= 3'd0;
      len     <= 7'd0;
      tmo_cnt <= 8'd0;
      res_ok  <= 1'b0;
      res_tmo <= 1'b0;
      res_src <= 3'd0;
      res_len <= 7'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            grant   <= pick;
            len     <= 7'd0;
            tmo_cnt <= 8'd0;
          end
        end
        S_STREAM: begin
          if (xfer) begin
            tmo_cnt <= 8'd0;
            if (is_term) begin
              res_ok  <= (rec_state == AFT_D) && ({1'b0, len} <= MAXLEN_L);
              res_tmo <= 1'b0;
              res_src <= grant;
              res_len <= len;
            end else if (len != 7'h7F) begin
              len <= len + 7'd1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
            if (tmo_hit) begin
              res_ok  <= 1'b0;
              res_tmo <= 1'b1;
              res_src <= grant;
              res_len <= len;
            end
          end
        end
        S_DONE: begin
          rr_ptr <= (grant == 3'(NREQ - 1)) ? 3'd0 : grant + 3'd1;
        end
        default: ;
      endcase
    end
  end

  expr_check_core u_core (
    .clk   (clk),
    .clr   (clr),
    .start (rec_start),
    .en    (rec_en),
    .ch    (gdata),
    .state (rec_state)
  );

endmodule

// File: tb/tb_expr_stream_arbiter.sv
// tb/tb_expr_stream_arbiter.sv - self-checking bench for expr_stream_arbiter with two sources
module tb_expr_stream_arbiter;

  localparam int         MAXLEN = 64;
  localparam logic [7:0] TERM_B = 8'h3D;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [15:0] req_data = 16'h0000;
  logic [1:0]  req_ready;
  logic        busy, res_valid, res_ok, res_tmo;
  logic [2:0]  res_src;
  logic [6:0]  res_len;

  expr_stream_arbiter #(.NREQ(2), .MAXLEN(MAXLEN), .TIMEOUT(255), .TERM(TERM_B)) dut (
    .clk(clk), .clr(clr), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .busy(busy), .res_valid(res_valid), .res_ok(res_ok),
    .res_tmo(res_tmo), .res_src(res_src), .res_len(res_len)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int both_rdy = 0;

  logic [7:0] tx0[$];
  logic [7:0] tx1[$];
  bit pend0 = 0, pend1 = 0, v0 = 0, v1 = 0, rand_gap = 0;
  int term_cyc0 = 0, term_cyc1 = 0, last_x0 = 0, last_x1 = 0;

  logic       rq_ok[$];
  logic       rq_tmo[$];
  logic [2:0] rq_src[$];
  logic [6:0] rq_len[$];
  int         rq_cyc[$];

  logic       e0_ok[$], e1_ok[$];
  logic [6:0] e0_len[$], e1_len[$];

  always @(posedge clk) cyc++;

  // Source drivers: a byte is popped once the edge after it was presented saw valid && ready.
  always @(negedge clk) begin
    if (pend0 && tx0.size() > 0) void'(tx0.pop_front());
    if (pend1 && tx1.size() > 0) void'(tx1.pop_front());
    v0 = (tx0.size() > 0) && (!rand_gap || $urandom_range(3) != 0);
    v1 = (tx1.size() > 0) && (!rand_gap || $urandom_range(3) != 0);
    req_valid[0] = v0;
    req_valid[1] = v1;
    req_data[7:0]  = v0 ? tx0[0] : 8'h00;
    req_data[15:8] = v1 ? tx1[0] : 8'h00;
    pend0 = v0 && req_ready[0] && !clr;
    pend1 = v1 && req_ready[1] && !clr;
    if (pend0) begin last_x0 = cyc; if (tx0[0] == TERM_B) term_cyc0 = cyc; end
    if (pend1) begin last_x1 = cyc; if (tx1[0] == TERM_B) term_cyc1 = cyc; end
  end

  always @(negedge clk) begin
    if (req_ready == 2'b11) both_rdy++;
    if (res_valid) begin
      rq_ok.push_back(res_ok);
      rq_tmo.push_back(res_tmo);
      rq_src.push_back(res_src);
      rq_len.push_back(res_len);
      rq_cyc.push_back(cyc);
    end
  end

  function automatic bit model_ok(input bq_t e);
    if (e.size() == 0 || e.size() > MAXLEN || (e.size() % 2) == 0) return 1'b0;
    foreach (e[p]) begin
      if ((p % 2) == 0) begin
        if (!(e[p] >= "0" && e[p] <= "9")) return 1'b0;
      end else begin
        if (!(e[p] == "+" || e[p] == "*")) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  task automatic push_str(input int s, input string str);
    for (int i = 0; i < str.len(); i++) begin
      if (s == 0) tx0.push_back(str[i]);
      else        tx1.push_back(str[i]);
    end
  endtask

  task automatic clear_res();
    rq_ok.delete(); rq_tmo.delete(); rq_src.delete(); rq_len.delete(); rq_cyc.delete();
  endtask

  task automatic wait_res(input int n, input int budget, input string nm);
    int k = 0;
    while (rq_ok.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    if (rq_ok.size() < n) begin
      total++; bad++;
      $display("FAIL %s_wait: results=%0d required=%0d", nm, rq_ok.size(), n);
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({req_ready, busy, res_valid, res_ok, res_tmo, res_src, res_len} !== 16'h0000) begin
      bad++;
      $display("FAIL reset_outputs: got=%h required=0000",
               {req_ready, busy, res_valid, res_ok, res_tmo, res_src, res_len});
    end
  endtask

  task automatic test_both_from_reset();
    clear_res();
    push_str(0, "1+1=");
    push_str(1, "1+1=");
    repeat (2) @(negedge clk);
    total++;
    if (req_ready !== 2'b00) begin
      bad++; $display("FAIL ready_in_clr: got=%b required=00", req_ready);
    end
    clr = 1'b0;
    wait_res(2, 100, "both");
    if (rq_ok.size() >= 2) begin
      total++;
      if (rq_src[0] !== 3'd0 || rq_src[1] !== 3'd1) begin
        bad++; $display("FAIL both_order: got=%0d,%0d required=0,1", rq_src[0], rq_src[1]);
      end
      total++;
      if (rq_ok[0] !== 1'b1 || rq_ok[1] !== 1'b1 || rq_len[0] !== 7'd3 || rq_len[1] !== 7'd3) begin
        bad++; $display("FAIL both_verdict: ok=%b%b len=%0d,%0d required ok=11 len=3,3",
                        rq_ok[0], rq_ok[1], rq_len[0], rq_len[1]);
      end
    end
    total++;
    if (both_rdy !== 0) begin
      bad++; $display("FAIL ready_onehot: got=%0d cycles with 11 required=0", both_rdy);
    end
  endtask

  task automatic test_single_ok();
    clear_res();
    push_str(0, "3+4*5=");
    wait_res(1, 100, "single");
    if (rq_ok.size() >= 1) begin
      total++;
      if (rq_ok[0] !== 1'b1 || rq_tmo[0] !== 1'b0 || rq_src[0] !== 3'd0 || rq_len[0] !== 7'd5) begin
        bad++; $display("FAIL single_fields: ok=%b tmo=%b src=%0d len=%0d required 1 0 0 5",
                        rq_ok[0], rq_tmo[0], rq_src[0], rq_len[0]);
      end
      total++;
      if (rq_cyc[0] !== term_cyc0 + 1) begin
        bad++; $display("FAIL single_latency: got=%0d required=%0d", rq_cyc[0], term_cyc0 + 1);
      end
    end
  endtask

  task automatic test_short();
    clear_res();
    push_str(1, "3+=");
    push_str(1, "=");
    wait_res(2, 100, "short");
    if (rq_ok.size() >= 2) begin
      total++;
      if (rq_ok[0] !== 1'b0 || rq_len[0] !== 7'd2 || rq_src[0] !== 3'd1) begin
        bad++; $display("FAIL trailing_op: ok=%b len=%0d src=%0d required 0 2 1",
                        rq_ok[0], rq_len[0], rq_src[0]);
      end
      total++;
      if (rq_ok[1] !== 1'b0 || rq_len[1] !== 7'd0 || rq_src[1] !== 3'd1) begin
        bad++; $display("FAIL term_only: ok=%b len=%0d src=%0d required 0 0 1",
                        rq_ok[1], rq_len[1], rq_src[1]);
      end
    end
  endtask

  task automatic test_timeout();
    int gap;
    clear_res();
    push_str(0, "7+");
    wait_res(1, 600, "timeout");
    if (rq_ok.size() >= 1) begin
      total++;
      if (rq_tmo[0] !== 1'b1 || rq_ok[0] !== 1'b0 || rq_len[0] !== 7'd2) begin
        bad++; $display("FAIL timeout_fields: tmo=%b ok=%b len=%0d required 1 0 2",
                        rq_tmo[0], rq_ok[0], rq_len[0]);
      end
      gap = rq_cyc[0] - last_x0;
      total++;
      if (gap < 256 || gap > 257) begin
        bad++; $display("FAIL timeout_delay: got=%0d required=256..257", gap);
      end
    end
  endtask

  task automatic test_maxlen();
    string s = "1";
    clear_res();
    for (int i = 0; i < 32; i++) s = {s, "+1"};
    s = {s, "="};
    push_str(0, s);
    wait_res(1, 300, "maxlen");
    if (rq_ok.size() >= 1) begin
      total++;
      if (rq_ok[0] !== 1'b0 || rq_tmo[0] !== 1'b0 || rq_len[0] !== 7'd65) begin
        bad++; $display("FAIL maxlen: ok=%b tmo=%b len=%0d required 0 0 65",
                        rq_ok[0], rq_tmo[0], rq_len[0]);
      end
    end
  endtask

  task automatic test_clr_mid();
    int k = 0;
    clear_res();
    push_str(0, "2*");
    while (tx0.size() > 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    total++;
    if ({req_ready, busy, res_valid, res_ok, res_tmo, res_src, res_len} !== 16'h0000) begin
      bad++; $display("FAIL clr_outputs: got=%h required=0000",
                      {req_ready, busy, res_valid, res_ok, res_tmo, res_src, res_len});
    end
    @(negedge clk);
    clr = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (rq_ok.size() !== 0) begin
      bad++; $display("FAIL clr_no_result: got=%0d results required=0", rq_ok.size());
    end
    push_str(0, "9=");
    wait_res(1, 100, "after_clr");
    if (rq_ok.size() >= 1) begin
      total++;
      if (rq_ok[0] !== 1'b1 || rq_len[0] !== 7'd1 || rq_src[0] !== 3'd0) begin
        bad++; $display("FAIL after_clr: ok=%b len=%0d src=%0d required 1 1 0",
                        rq_ok[0], rq_len[0], rq_src[0]);
      end
    end
  endtask

  task automatic test_random();
    bq_t e;
    int n, s;
    logic [7:0] b;
    logic eok;
    logic [6:0] elen;
    clear_res();
    rand_gap = 1;
    for (int x = 0; x < 40; x++) begin
      s = x % 2;
      n = $urandom_range(0, 9);
      e.delete();
      for (int p = 0; p < n; p++) begin
        if ((p % 2) == 0) b = 8'h30 + 8'($urandom_range(0, 9));
        else              b = ($urandom_range(1) == 1) ? 8'h2B : 8'h2A;
        if ($urandom_range(5) == 0) begin
          b = 8'($urandom_range(255));
          if (b == TERM_B) b = 8'hFF;
        end
        e.push_back(b);
      end
      foreach (e[p]) begin
        if (s == 0) tx0.push_back(e[p]);
        else        tx1.push_back(e[p]);
      end
      if (s == 0) tx0.push_back(TERM_B);
      else        tx1.push_back(TERM_B);
      if (s == 0) begin e0_ok.push_back(model_ok(e)); e0_len.push_back(7'(n)); end
      else        begin e1_ok.push_back(model_ok(e)); e1_len.push_back(7'(n)); end
    end
    wait_res(40, 5000, "random");
    rand_gap = 0;
    for (int r = 0; r < rq_ok.size(); r++) begin
      if (rq_src[r] == 3'd0 && e0_ok.size() > 0) begin
        eok = e0_ok.pop_front(); elen = e0_len.pop_front();
      end else if (rq_src[r] == 3'd1 && e1_ok.size() > 0) begin
        eok = e1_ok.pop_front(); elen = e1_len.pop_front();
      end else begin
        total++; bad++;
        $display("FAIL random_src: result %0d src=%0d has no pending expression", r, rq_src[r]);
        continue;
      end
      total++;
      if (rq_ok[r] !== eok || rq_len[r] !== elen || rq_tmo[r] !== 1'b0) begin
        bad++; $display("FAIL random_result %0d: ok=%b len=%0d tmo=%b required ok=%b len=%0d tmo=0",
                        r, rq_ok[r], rq_len[r], rq_tmo[r], eok, elen);
      end
    end
    total++;
    if (e0_ok.size() + e1_ok.size() != 0) begin
      bad++; $display("FAIL random_left: got=%0d unanswered required=0", e0_ok.size() + e1_ok.size());
    end
  endtask

  initial begin
    test_reset();
    test_both_from_reset();
    test_single_ok();
    test_short();
    test_timeout();
    test_maxlen();
    test_clr_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
